cpu_sequencer: RTL and testbench

Multi-cycle sequencer for the RV32I core. It breaks each instruction into fetch, decode, execute, memory and writeback steps, and holds the PC, IR, register-file and memory enables until each step is allowed. It sits between the combinational instruction decoder and the datapath registers. It qualifies the decoder's raw `wen_reg`/`wen_mem` with state, handles the memory ready handshake, and stops the core on ECALL/EBREAK, an illegal opcode or a memory timeout.

---
 rtl/cpu_pkg.sv | 43 ++++
 rtl/cpu_sequencer_if.sv | 31 +++
 rtl/mem_wait_timer.sv | 36 +++
 rtl/cpu_sequencer.sv | 117 +++++++++++
 tb/tb_cpu_sequencer.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared types and RV32I major opcodes for the multi-cycle sequencer.
package cpu_pkg;

  typedef enum logic [2:0] {
    StFetch     = 3'd0,
    StFetchWait = 3'd1,
    StDecode    = 3'd2,
    StExecute   = 3'd3,
    StMemory    = 3'd4,
    StWriteback = 3'd5,
    StHalt      = 3'd6
  } seq_state_t;

  typedef enum logic [1:0] {
    CauseNone    = 2'b00,
    CauseEcall   = 2'b01,
    CauseIllegal = 2'b10,
    CauseTimeout = 2'b11
  } halt_cause_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // SYSTEM is handled separately as a halt, so it is not listed here.
  function automatic logic is_legal_op(logic [6:0] op);
    logic legal;
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_IMM, OP_REG: legal = 1'b1;
      default:                           legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Decoder/memory/datapath-facing signals of the sequencer.
interface cpu_sequencer_if;

  logic [6:0]  opcode;
  logic        wen_reg_dec;
  logic        wen_mem_dec;
  logic        mem_ready;
  logic        imem_rd_en;
  logic        ir_we;
  logic        dmem_rd_en;
  logic        dmem_wr_en;
  logic        reg_we;
  logic        pc_we;
  logic        halted;
  logic [1:0]  halt_cause;
  logic [2:0]  state_dbg;
  logic [31:0] instret;

  modport master (
    input  opcode, wen_reg_dec, wen_mem_dec, mem_ready,
    output imem_rd_en, ir_we, dmem_rd_en, dmem_wr_en, reg_we, pc_we,
    output halted, halt_cause, state_dbg, instret
  );

  modport slave (
    output opcode, wen_reg_dec, wen_mem_dec, mem_ready,
    input  imem_rd_en, ir_we, dmem_rd_en, dmem_wr_en, reg_we, pc_we,
    input  halted, halt_cause, state_dbg, instret
  );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory wait state.
module mem_wait_timer #(
  parameter int unsigned MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam logic [7:0] LastIdx = 8'(MAX - 1);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_en) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // High on the MAX-th consecutive not-ready cycle; a ready cycle never expires.
  assign expired = count_en && (count_q == LastIdx);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle RV32I sequencer: steps each instruction and gates datapath strobes by state.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input logic             clk,
  input logic             rst_n,
  cpu_sequencer_if.master bus
);

  seq_state_t  state_q, state_d;
  halt_cause_t cause_q, cause_d;
  logic [31:0] instret_q, instret_d;
  logic        in_wait;
  logic        expired;
  logic        is_load;
  logic        is_store;

  assign in_wait  = (state_q == StFetchWait) || (state_q == StMemory);
  assign is_load  = (bus.opcode == OP_LOAD);
  assign is_store = (bus.opcode == OP_STORE);

  mem_wait_timer #(
    .MAX(MEM_WAIT_MAX)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (!in_wait),
    .count_en (in_wait && !bus.mem_ready),
    .expired  (expired)
  );

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    instret_d = instret_q;
    case (state_q)
      StFetch: state_d = StFetchWait;
      StFetchWait, StMemory: begin
        if (bus.mem_ready) begin
          state_d = (state_q == StFetchWait) ? StDecode : StWriteback;
        end else if (expired) begin
          state_d = StHalt;
          cause_d = CauseTimeout;
        end
      end
      StDecode: begin
        if (bus.opcode == OP_SYSTEM) begin
          state_d = StHalt;
          cause_d = CauseEcall;
        end else if (!is_legal_op(bus.opcode)) begin
          state_d = StHalt;
          cause_d = CauseIllegal;
        end else begin
          state_d = StExecute;
        end
      end
      StExecute: state_d = (is_load || is_store) ? StMemory : StWriteback;
      StWriteback: begin
        state_d   = StFetch;
        instret_d = instret_q + 32'd1;
      end
      StHalt: state_d = StHalt;
      default: begin
        state_d = StHalt;
        cause_d = CauseIllegal;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      cause_q   <= CauseNone;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

  // Strobes are held low for the whole reset cycle, whatever the current state.
  always_comb begin
    bus.imem_rd_en = 1'b0;
    bus.ir_we      = 1'b0;
    bus.dmem_rd_en = 1'b0;
    bus.dmem_wr_en = 1'b0;
    bus.reg_we     = 1'b0;
    bus.pc_we      = 1'b0;
    if (rst_n) begin
      case (state_q)
        StFetch: bus.imem_rd_en = 1'b1;
        StFetchWait: begin
          bus.imem_rd_en = 1'b1;
          bus.ir_we      = bus.mem_ready;
        end
        StMemory: begin
          bus.dmem_rd_en = is_load;
          bus.dmem_wr_en = is_store && bus.wen_mem_dec;
        end
        StWriteback: begin
          bus.reg_we = bus.wen_reg_dec;
          bus.pc_we  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.halted     = (state_q == StHalt);
  assign bus.halt_cause = cause_q;
  assign bus.state_dbg  = state_q;
  assign bus.instret    = instret_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: directed instructions, a reactive memory, event monitor.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  localparam int unsigned WaitMax = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  cpu_sequencer_if bus ();

  cpu_sequencer #(
    .MEM_WAIT_MAX(WaitMax)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_halt;
    int cause;
    int cyc;
    int n_ir;
    int n_rd;
    int n_wr;
    int reg_we;
    int instret;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   ev_cnt = 0;
  int   fw_cfg = 0;
  int   dw_cfg = 0;
  bit   toggle = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] strobes();
    return {26'd0, bus.imem_rd_en, bus.ir_we, bus.dmem_rd_en, bus.dmem_wr_en,
            bus.reg_we, bus.pc_we};
  endfunction

  // Reactive memory: ready after fw_cfg / dw_cfg not-ready wait cycles.
  int f_idx = 0;
  int d_idx = 0;
  bit par = 1'b0;
  always begin
    @(posedge clk);
    #2;
    if (bus.imem_rd_en) f_idx++; else f_idx = 0;
    if (bus.dmem_rd_en || bus.dmem_wr_en) d_idx++; else d_idx = 0;
    par = ~par;
    bus.mem_ready = (bus.imem_rd_en && f_idx >= 2 + fw_cfg) ||
                    ((bus.dmem_rd_en || bus.dmem_wr_en) && d_idx >= 1 + dw_cfg) ||
                    (toggle && par);
  end

  // Monitor: pops an expectation on every retire (pc_we) or halt entry.
  int   cyc = 0, n_ir = 0, n_rd = 0, n_wr = 0, n_rw = 0;
  bit   halted_seen = 1'b0;
  bit   pend = 1'b0;
  int   pend_instret = 0;
  int   halt_instret = 0;
  exp_t e;
  always @(negedge clk) begin
    if (!rst_n) begin
      cyc = 0; n_ir = 0; n_rd = 0; n_wr = 0; n_rw = 0;
      halted_seen = 1'b0;
      pend = 1'b0;
    end else begin
      if (pend) begin
        chk("next_is_fetch", 32'(bus.state_dbg), 32'(StFetch));
        chk("instret_after", bus.instret, pend_instret);
        pend = 1'b0;
      end
      if (bus.halted) begin
        chk("halt_quiet", strobes(), 32'd0);
        if (!halted_seen) begin
          halted_seen = 1'b1;
          ev_cnt++;
          chk("queue_has_entry", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("event_is_halt", 32'd1, 32'(e.is_halt));
            chk("halt_cause", 32'(bus.halt_cause), e.cause);
            chk("halt_cycles", cyc, e.cyc);
            chk("halt_ir_pulses", n_ir, e.n_ir);
            chk("halt_rd_cycles", n_rd, e.n_rd);
            chk("halt_instret", bus.instret, e.instret);
            halt_instret = e.instret;
          end
        end else begin
          chk("halt_instret_held", bus.instret, halt_instret);
        end
      end else begin
        cyc++;
        n_ir += 32'(bus.ir_we);
        n_rd += 32'(bus.dmem_rd_en);
        n_wr += 32'(bus.dmem_wr_en);
        n_rw += 32'(bus.reg_we);
        if (bus.pc_we) begin
          ev_cnt++;
          chk("queue_has_entry", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("event_is_halt", 32'd0, 32'(e.is_halt));
            chk("retire_cycles", cyc, e.cyc);
            chk("ir_pulses", n_ir, e.n_ir);
            chk("dmem_rd_cycles", n_rd, e.n_rd);
            chk("dmem_wr_cycles", n_wr, e.n_wr);
            chk("reg_we_at_pc_we", 32'(bus.reg_we), e.reg_we);
            chk("reg_we_pulses", n_rw, e.reg_we);
            chk("instret_before", bus.instret, e.instret);
            pend = 1'b1;
            pend_instret = e.instret + 1;
          end
          cyc = 0; n_ir = 0; n_rd = 0; n_wr = 0; n_rw = 0;
        end
      end
    end
  end

  task automatic set_instr(input logic [6:0] op, input logic wr, input logic wm,
                           input int fw, input int dw);
    bus.opcode      = op;
    bus.wen_reg_dec = wr;
    bus.wen_mem_dec = wm;
    fw_cfg          = fw;
    dw_cfg          = dw;
  endtask

  task automatic expect_retire(input int c, input int rd, input int wr, input int rw,
                               input int ir);
    exp_t x;
    x = '{is_halt: 1'b0, cause: 0, cyc: c, n_ir: 1, n_rd: rd, n_wr: wr, reg_we: rw,
          instret: ir};
    sb.push_back(x);
  endtask

  task automatic expect_halt(input int cause, input int c, input int nir, input int rd,
                             input int ir);
    exp_t x;
    x = '{is_halt: 1'b1, cause: cause, cyc: c, n_ir: nir, n_rd: rd, n_wr: 0, reg_we: 0,
          instret: ir};
    sb.push_back(x);
  endtask

  task automatic wait_event(input string name);
    int start;
    bit got;
    start = ev_cnt;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      #1;
      if (ev_cnt != start) got = 1'b1;
    end
    chk({name, "_completed"}, 32'(got), 32'd1);
    if (!got) sb.delete();
  endtask

  task automatic reset_and_release(input int n);
    @(posedge clk);
    #1 rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("reset_strobes", strobes(), 32'd0);
      if (i >= 1) begin
        chk("reset_state", 32'(bus.state_dbg), 32'(StFetch));
        chk("reset_instret", bus.instret, 32'd0);
        chk("reset_halted", 32'(bus.halted), 32'd0);
        chk("reset_cause", 32'(bus.halt_cause), 32'd0);
      end
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    set_instr(OP_IMM, 1'b1, 1'b0, 0, 0);
    expect_retire(5, 0, 0, 1, 0);
    reset_and_release(3);
    @(negedge clk);
    chk("first_fetch", 32'(bus.imem_rd_en), 32'd1);
    wait_event("addi");

    set_instr(OP_LOAD, 1'b1, 1'b0, 0, 3);
    expect_retire(9, 4, 0, 1, 1);
    wait_event("lw_slow");

    set_instr(OP_STORE, 1'b0, 1'b1, 0, 0);
    expect_retire(6, 0, 1, 0, 2);
    wait_event("sw");

    set_instr(OP_IMM, 1'b1, 1'b0, 2, 0);
    expect_retire(7, 0, 0, 1, 3);
    wait_event("addi_slow_fetch");

    set_instr(OP_JAL, 1'b1, 1'b0, 0, 0);
    expect_retire(5, 0, 0, 1, 4);
    wait_event("jal");

    set_instr(OP_BRANCH, 1'b0, 1'b0, 0, 0);
    expect_retire(5, 0, 0, 0, 5);
    wait_event("branch");

    set_instr(7'b0000000, 1'b1, 1'b0, 0, 0);
    expect_halt(int'(CauseIllegal), 3, 1, 0, 6);
    wait_event("illegal");
    toggle = 1'b1;
    repeat (6) @(negedge clk);
    toggle = 1'b0;

    set_instr(OP_SYSTEM, 1'b0, 1'b0, 0, 0);
    expect_halt(int'(CauseEcall), 3, 1, 0, 0);
    reset_and_release(2);
    wait_event("ecall");

    set_instr(OP_IMM, 1'b1, 1'b0, 99, 0);
    expect_halt(int'(CauseTimeout), 5, 0, 0, 0);
    reset_and_release(2);
    wait_event("fetch_timeout");

    set_instr(OP_LOAD, 1'b1, 1'b0, 0, 99);
    expect_halt(int'(CauseTimeout), 8, 1, 4, 0);
    reset_and_release(2);
    wait_event("mem_timeout");

    // Reset in the second MEMORY cycle of a stalled load.
    set_instr(OP_LOAD, 1'b1, 1'b0, 0, 99);
    reset_and_release(2);
    repeat (5) @(negedge clk);
    chk("pre_reset_rd", 32'(bus.dmem_rd_en), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("mid_reset_strobes", strobes(), 32'd0);
    set_instr(OP_IMM, 1'b1, 1'b0, 0, 0);
    expect_retire(5, 0, 0, 1, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_reset_fetch", 32'(bus.state_dbg), 32'(StFetch));
    chk("mid_reset_imem", 32'(bus.imem_rd_en), 32'd1);
    wait_event("after_mid_reset");

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
